// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   state_e        : controller states (IDLE, ADJUST, SHIFT, DONE)
//   BCD_DIGIT_W    : bits per packed BCD digit
//   ADD3_THRESHOLD : digit value at or above which the add-3 correction applies
//   digits_needed  : decimal digits required to show 2^width-1
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADJUST = 2'd1,
    SHIFT  = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int         BCD_DIGIT_W    = 4;
  localparam logic [3:0] ADD3_THRESHOLD = 4'd5;

  function automatic int digits_needed(input int width);
    longint unsigned v;
    int              n;
    v = (longint'(1) << width) - 1;
    n = 1;
    while (v >= 10) begin
      v = v / 10;
      n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_seq_converter_if.sv
// Request/result bundle of the BCD converter.
//   start   : conversion request (master -> slave)
//   bin_in  : binary operand (master -> slave)
//   busy    : converter not idle (slave -> master)
//   valid   : one-cycle result strobe (slave -> master)
//   bcd_out : packed BCD result, units in [3:0] (slave -> master)
interface bcd_seq_converter_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic                  busy;
  logic                  valid;
  logic [4*DIGITS-1:0]   bcd_out;

  modport master (output start, output bin_in, input busy, input valid, input bcd_out);
  modport slave  (input start, input bin_in, output busy, output valid, output bcd_out);
endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit corrector: adds 3 (mod 16) to a digit that is 5 or more,
// so the following left shift carries correctly into the next decimal digit.
//   d : BCD digit before correction
//   q : corrected digit
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= ADD3_THRESHOLD) ? d + 4'd3 : d;
endmodule

// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per
// ADJUST/SHIFT pair, so a conversion takes 2*WIDTH cycles plus DONE.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of bcd_seq_converter_if (start/bin_in in, busy/valid/bcd_out out)
//
// state  | meaning
// IDLE   | waiting for start; operand captured on the accepting edge
// ADJUST | add 3 to every BCD digit >= 5
// SHIFT  | shift {bcd_sr,bin_sr} left one bit; last shift publishes bcd_out
// DONE   | valid high for one cycle; start ignored
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input logic                clk,
  input logic                rst_n,
  bcd_seq_converter_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = BCD_DIGIT_W * DIGITS;

  localparam logic [1:0] ST_IDLE   = 2'(IDLE);
  localparam logic [1:0] ST_ADJUST = 2'(ADJUST);
  localparam logic [1:0] ST_SHIFT  = 2'(SHIFT);
  localparam logic [1:0] ST_DONE   = 2'(DONE);

  generate
    if (DIGITS < digits_needed(WIDTH)) begin : g_digits_check
      $error("bcd_seq_converter: DIGITS too small for WIDTH");
    end
  endgenerate

  logic [1:0]             state_q;
  logic [WIDTH-1:0]       bin_sr;
  logic [BCD_W-1:0]       bcd_sr;
  logic [CNT_W-1:0]       cnt;
  logic [BCD_W-1:0]       bcd_q;
  logic                   busy_q;
  logic                   valid_q;
  logic [BCD_W-1:0]       bcd_adj;
  logic [BCD_W+WIDTH-1:0] shifted;

  for (genvar i = 0; i < DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .d(bcd_sr[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .q(bcd_adj[i*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // bcd_sr and bin_sr behave as one long register; the operand MSB feeds the units digit.
  assign shifted = {bcd_sr[BCD_W-2:0], bin_sr, 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bin_sr  <= '0;
      bcd_sr  <= '0;
      cnt     <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            bin_sr  <= bus.bin_in;
            bcd_sr  <= '0;
            cnt     <= CNT_W'(WIDTH);
            state_q <= ST_ADJUST;
            busy_q  <= 1'b1;
          end
        end
        ST_ADJUST: begin
          bcd_sr  <= bcd_adj;
          state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          {bcd_sr, bin_sr} <= shifted;
          cnt              <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            bcd_q   <= shifted[BCD_W+WIDTH-1:WIDTH];
            valid_q <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_ADJUST;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.valid   = valid_q;
  assign bus.bcd_out = bcd_q;

endmodule

// File: tb/tb_bcd_seq_converter.sv
module tb_bcd_seq_converter;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  bcd_seq_converter_if #(.WIDTH(8), .DIGITS(3)) bus ();

  bcd_seq_converter #(.WIDTH(8), .DIGITS(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Reference: decimal digits by plain arithmetic.
  function automatic logic [11:0] ref_bcd(input int v);
    return 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
  endfunction

  function automatic logic digits_ok(input logic [11:0] b);
    return (b[3:0] <= 4'd9) && (b[7:4] <= 4'd9) && (b[11:8] <= 4'd9);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One conversion; accept edge is edge 0, valid expected after edge 16.
  task automatic run_conv(input logic [7:0] v, input bit noise);
    int k;
    bit busy_ok;
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.bin_in = v;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_accept", 32'(bus.busy), 32'd1);
    busy_ok = 1'b1;
    k = 0;
    while (!bus.valid && k < 40) begin
      if (noise) begin
        bus.start  = 1'($urandom_range(0, 1));
        bus.bin_in = 8'($urandom);
      end
      @(posedge clk); #1;
      k++;
      if (!bus.busy) busy_ok = 1'b0;
    end
    bus.start = 1'b0;
    check("latency", 32'(k), 32'd16);
    check("busy_during", 32'(busy_ok), 32'd1);
    check("bcd_out", 32'(bus.bcd_out), 32'(ref_bcd(int'(v))));
    check("digits", 32'(digits_ok(bus.bcd_out)), 32'd1);
    @(posedge clk); #1;
    check("valid_pulse", 32'(bus.valid), 32'd0);
    check("busy_drop", 32'(bus.busy), 32'd0);
    check("bcd_hold", 32'(bus.bcd_out), 32'(ref_bcd(int'(v))));
  endtask

  initial begin
    int order[256];
    int n, lows, k;
    bit sawv;
    logic [7:0] dir_vals[6];

    bus.start  = 1'b0;
    bus.bin_in = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_bcd", 32'(bus.bcd_out), 32'd0);
    rst_n = 1'b1;

    run_conv(8'd255, 1'b0);

    dir_vals = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd128};
    foreach (dir_vals[i]) run_conv(dir_vals[i], 1'b0);

    // Extra start pulses and operand change mid-conversion are ignored.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.bin_in = 8'd200;
    @(posedge clk); #1;
    bus.start = 1'b0;
    sawv = 1'b0; n = 0;
    for (int c = 1; c <= 40; c++) begin
      bus.start = (c == 3 || c == 10);
      if (c == 5) bus.bin_in = 8'd55;
      @(posedge clk); #1;
      if (bus.valid) begin
        n++;
        if (n == 1) check("extra_start_bcd", 32'(bus.bcd_out), 32'h200);
      end
    end
    bus.start = 1'b0;
    check("extra_start_valid_count", 32'(n), 32'd1);

    // Exhaustive sweep in shuffled order with random noise on start/bin_in.
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(0, i));
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < 256; i++) run_conv(8'(order[i]), 1'b1);

    // Back-to-back with start held high.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.bin_in = 8'd77;
    k = 0;
    while (!bus.valid && k < 40) begin @(posedge clk); #1; k++; end
    check("cont_first_valid", 32'(bus.valid), 32'd1);
    check("cont_bcd1", 32'(bus.bcd_out), 32'h077);
    n = 0; lows = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (!bus.busy) lows++;
    end while (!bus.valid && n < 60);
    check("cont_period", 32'(n), 32'd18);
    check("cont_idle_cycles", 32'(lows), 32'd1);
    check("cont_bcd2", 32'(bus.bcd_out), 32'h077);
    bus.start = 1'b0;
    repeat (3) @(posedge clk);

    // Asynchronous reset mid-conversion.
    #1;
    bus.start = 1'b1; bus.bin_in = 8'd143;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_valid", 32'(bus.valid), 32'd0);
    check("arst_bcd", 32'(bus.bcd_out), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sawv = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.valid) sawv = 1'b1;
    end
    check("arst_no_valid", 32'(sawv), 32'd0);
    check("arst_idle", 32'(bus.busy), 32'd0);
    run_conv(8'd143, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
